fetch_stage: RTL and testbench

- Instruction-fetch stage of the RV32I pipeline.
- Owns the fetch PC and a direct-mapped branch target buffer with 2-bit saturating counters.
- Drives the instruction-memory address and registers the F/D pipeline outputs (pcD, instD) that feed decode.
- Redirects on fail_predictE/nextpc from execute and holds on stall; this is the producer side of the same stall/flush contract the decode/execute register honours.

---
 rtl/rv32i_pkg.sv | 23 ++
 rtl/fetch_stage_btb.sv | 73 +++++++
 rtl/fetch_stage.sv | 77 +++++++
 tb/tb_fetch_stage.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline definitions: widths, bubble encoding and the
// 2-bit branch predictor counter helpers.
package rv32i_pkg;

    localparam int          PC_W     = 13;
    localparam logic [31:0] NOP_INST = 32'd0;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == ST) ? ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == SNT) ? SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/fetch_stage_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// One combinational lookup port and one registered update port.
module btb
    import rv32i_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int PC_W  = rv32i_pkg::PC_W
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [PC_W-1:0] i_lookup_pc,
    output logic            o_pred_taken,
    output logic [PC_W-1:0] o_pred_target,
    input  logic            i_upd_valid,
    input  logic [PC_W-1:0] i_upd_pc,
    input  logic            i_upd_taken,
    input  logic [PC_W-1:0] i_upd_target
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = PC_W - IDX_W - 2;

    logic              r_valid  [ENTRIES];
    logic [TAG_W-1:0]  r_tag    [ENTRIES];
    logic [PC_W-1:0]   r_target [ENTRIES];
    logic [1:0]        r_ctr    [ENTRIES];

    logic [IDX_W-1:0]  w_idx;
    logic [IDX_W-1:0]  w_uidx;
    logic [TAG_W-1:0]  w_tag;
    logic [TAG_W-1:0]  w_utag;
    logic              w_hit;
    logic              w_uhit;
    logic              w_unused_lsb;

    assign w_idx  = i_lookup_pc[IDX_W+1:2];
    assign w_tag  = i_lookup_pc[PC_W-1:IDX_W+2];
    assign w_uidx = i_upd_pc[IDX_W+1:2];
    assign w_utag = i_upd_pc[PC_W-1:IDX_W+2];

    // Instructions are word aligned, so the byte-offset bits carry no information.
    assign w_unused_lsb = ^{i_lookup_pc[1:0], i_upd_pc[1:0]};

    assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_uhit        = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
    assign o_pred_taken  = w_hit && r_ctr[w_idx][1];
    assign o_pred_target = r_target[w_idx];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= WNT;
            end
        end else if (i_upd_valid) begin
            if (w_uhit) begin
                r_ctr[w_uidx] <= i_upd_taken ? sat_inc(r_ctr[w_uidx]) : sat_dec(r_ctr[w_uidx]);
                if (i_upd_taken) begin
                    r_target[w_uidx] <= i_upd_target;
                end
            end else if (i_upd_taken) begin
                // Only taken branches allocate; a fresh entry starts weakly taken.
                r_valid[w_uidx]  <= 1'b1;
                r_tag[w_uidx]    <= w_utag;
                r_target[w_uidx] <= i_upd_target;
                r_ctr[w_uidx]    <= WT;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: fetch PC, BTB-driven next-PC selection and
// the F/D pipeline register, with redirect taking priority over stall.
module fetch_stage
    import rv32i_pkg::*;
#(
    parameter int              BTB_IDX_W = 4,
    parameter int              PC_W      = rv32i_pkg::PC_W,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic            CLK,
    input  logic            NRST,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            fail_predictE,
    input  logic [PC_W-1:0] nextpc,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    output logic [PC_W-1:0] pcD,
    output logic [31:0]     instD,
    output logic            pred_takenD
);

    logic [PC_W-1:0] r_pc_f;
    logic [PC_W-1:0] r_pc_d;
    logic [31:0]     r_inst_d;
    logic            r_pred_d;

    logic            w_pred_taken;
    logic [PC_W-1:0] w_pred_target;
    logic [PC_W-1:0] w_pred_next;

    btb #(
        .IDX_W (BTB_IDX_W),
        .PC_W  (PC_W)
    ) u_btb (
        .i_clk         (CLK),
        .i_rst_n       (NRST),
        .i_lookup_pc   (r_pc_f),
        .o_pred_taken  (w_pred_taken),
        .o_pred_target (w_pred_target),
        .i_upd_valid   (upd_valid),
        .i_upd_pc      (upd_pc),
        .i_upd_taken   (upd_taken),
        .i_upd_target  (upd_target)
    );

    // Sequential +4 wraps naturally at the PC width.
    assign w_pred_next = w_pred_taken ? w_pred_target : r_pc_f + PC_W'(4);

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_pc_f   <= RESET_PC;
            r_pc_d   <= '0;
            r_inst_d <= NOP_INST;
            r_pred_d <= 1'b0;
        end else if (fail_predictE) begin
            r_pc_f   <= nextpc;
            r_pc_d   <= '0;
            r_inst_d <= NOP_INST;
            r_pred_d <= 1'b0;
        end else if (!stall) begin
            r_pc_f   <= w_pred_next;
            r_pc_d   <= r_pc_f;
            r_inst_d <= imem_rdata;
            r_pred_d <= w_pred_taken;
        end
    end

    assign imem_addr   = r_pc_f;
    assign pcD         = r_pc_d;
    assign instD       = r_inst_d;
    assign pred_takenD = r_pred_d;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: reference PC/BTB model feeding a
// scoreboard of expected F/D register contents, plus directed scenario checks.
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        NRST = 1'b0;
    logic [12:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall = 1'b0;
    logic        fail_predictE = 1'b0;
    logic [12:0] nextpc = '0;
    logic        upd_valid = 1'b0;
    logic [12:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [12:0] upd_target = '0;
    logic [12:0] pcD;
    logic [31:0] instD;
    logic        pred_takenD;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [12:0] pc;
        logic [31:0] inst;
        logic        pred;
    } exp_t;

    exp_t        sb[$];
    exp_t        m_last;
    logic [12:0] m_pc;
    bit          m_valid [16];
    logic [6:0]  m_tag   [16];
    logic [12:0] m_tgt   [16];
    int          m_ctr   [16];

    fetch_stage dut (
        .CLK           (CLK),
        .NRST          (NRST),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .fail_predictE (fail_predictE),
        .nextpc        (nextpc),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .pcD           (pcD),
        .instD         (instD),
        .pred_takenD   (pred_takenD)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] inst_of(input logic [12:0] pc);
        return 32'hC0DE0000 | 32'(pc);
    endfunction

    assign imem_rdata = inst_of(imem_addr);

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
        m_pc   = 13'd0;
        m_last = '{pc: 13'd0, inst: 32'd0, pred: 1'b0};
        sb.delete();
    endtask

    task automatic clr();
        stall = 1'b0;
        fail_predictE = 1'b0;
        upd_valid = 1'b0;
        upd_taken = 1'b0;
    endtask

    // One clock: inputs are already set at the negedge; model the edge, then compare.
    task automatic tick();
        exp_t        e;
        exp_t        got;
        int          idx;
        int          uidx;
        bit          hit;
        bit          uhit;
        bit          pt;
        logic [12:0] nxt;
        checks++;
        if (imem_addr !== m_pc) begin
            errors++;
            $display("FAIL imem_addr got %h exp %h at %0t", imem_addr, m_pc, $time);
        end
        idx = int'(m_pc[5:2]);
        hit = m_valid[idx] && (m_tag[idx] == m_pc[12:6]);
        pt  = hit && (m_ctr[idx] >= 2);
        if (fail_predictE) begin
            e   = '{pc: 13'd0, inst: 32'd0, pred: 1'b0};
            nxt = nextpc;
        end else if (stall) begin
            e   = m_last;
            nxt = m_pc;
        end else begin
            e   = '{pc: m_pc, inst: inst_of(m_pc), pred: pt};
            nxt = pt ? m_tgt[idx] : m_pc + 13'd4;
        end
        if (upd_valid) begin
            uidx = int'(upd_pc[5:2]);
            uhit = m_valid[uidx] && (m_tag[uidx] == upd_pc[12:6]);
            if (!uhit) begin
                if (upd_taken) begin
                    m_valid[uidx] = 1'b1;
                    m_tag[uidx]   = upd_pc[12:6];
                    m_tgt[uidx]   = upd_target;
                    m_ctr[uidx]   = 2;
                end
            end else if (upd_taken) begin
                if (m_ctr[uidx] < 3) m_ctr[uidx]++;
                m_tgt[uidx] = upd_target;
            end else if (m_ctr[uidx] > 0) begin
                m_ctr[uidx]--;
            end
        end
        sb.push_back(e);
        @(posedge CLK);
        @(negedge CLK);
        m_pc   = nxt;
        m_last = e;
        got = sb.pop_front();
        checks++;
        if (pcD !== got.pc || instD !== got.inst || pred_takenD !== got.pred) begin
            errors++;
            $display("FAIL fd_reg got pc=%h inst=%h pred=%b exp pc=%h inst=%h pred=%b at %0t",
                     pcD, instD, pred_takenD, got.pc, got.inst, got.pred, $time);
        end
    endtask

    task automatic redirect(input logic [12:0] pc);
        fail_predictE = 1'b1;
        nextpc = pc;
        tick();
        clr();
    endtask

    task automatic update(input logic [12:0] pc, input logic taken, input logic [12:0] tgt);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = taken;
        upd_target = tgt;
        tick();
        clr();
    endtask

    task automatic test_reset();
        model_reset();
        NRST = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if (imem_addr !== 13'd0 || pcD !== 13'd0 || instD !== 32'd0 || pred_takenD !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got addr=%h pcD=%h inst=%h pred=%b exp all zero",
                     imem_addr, pcD, instD, pred_takenD);
        end
        NRST = 1'b1;
    endtask

    task automatic test_straight_line();
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (imem_addr !== 13'h010 || pcD !== 13'h00C || instD !== inst_of(13'h00C)) begin
            errors++;
            $display("FAIL straight_line got addr=%h pcD=%h exp addr=010 pcD=00C", imem_addr, pcD);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        clr();
        checks++;
        if (imem_addr !== 13'h010 || pcD !== 13'h00C || instD !== inst_of(13'h00C)) begin
            errors++;
            $display("FAIL stall_hold got addr=%h pcD=%h exp addr=010 pcD=00C", imem_addr, pcD);
        end
        tick();
        checks++;
        if (imem_addr !== 13'h014 || pcD !== 13'h010) begin
            errors++;
            $display("FAIL stall_release got addr=%h pcD=%h exp addr=014 pcD=010", imem_addr, pcD);
        end
    endtask

    task automatic test_redirect_over_stall();
        stall = 1'b1;
        redirect(13'h100);
        checks++;
        if (imem_addr !== 13'h100 || pcD !== 13'h000 || instD !== 32'd0) begin
            errors++;
            $display("FAIL redirect_flush got addr=%h pcD=%h inst=%h exp addr=100 pcD=0 inst=0",
                     imem_addr, pcD, instD);
        end
        tick();
        checks++;
        if (pcD !== 13'h100 || instD !== inst_of(13'h100)) begin
            errors++;
            $display("FAIL redirect_first got pcD=%h inst=%h exp pcD=100", pcD, instD);
        end
    endtask

    task automatic test_btb_alloc();
        update(13'h020, 1'b1, 13'h080);
        redirect(13'h018);
        repeat (3) tick();
        checks++;
        if (pcD !== 13'h020 || pred_takenD !== 1'b1 || imem_addr !== 13'h080) begin
            errors++;
            $display("FAIL btb_alloc got pcD=%h pred=%b addr=%h exp pcD=020 pred=1 addr=080",
                     pcD, pred_takenD, imem_addr);
        end
    endtask

    task automatic test_counter();
        update(13'h020, 1'b0, 13'h000);
        update(13'h020, 1'b0, 13'h000);
        redirect(13'h020);
        tick();
        checks++;
        if (pred_takenD !== 1'b0 || imem_addr !== 13'h024) begin
            errors++;
            $display("FAIL ctr_down got pred=%b addr=%h exp pred=0 addr=024", pred_takenD, imem_addr);
        end
        update(13'h020, 1'b1, 13'h080);
        update(13'h020, 1'b1, 13'h080);
        redirect(13'h020);
        tick();
        checks++;
        if (pred_takenD !== 1'b1 || imem_addr !== 13'h080) begin
            errors++;
            $display("FAIL ctr_up got pred=%b addr=%h exp pred=1 addr=080", pred_takenD, imem_addr);
        end
        // Three more takens must saturate, so one not-taken still leaves it taken.
        for (int i = 0; i < 3; i++) update(13'h020, 1'b1, 13'h0C0);
        update(13'h020, 1'b0, 13'h000);
        redirect(13'h020);
        tick();
        checks++;
        if (pred_takenD !== 1'b1 || imem_addr !== 13'h0C0) begin
            errors++;
            $display("FAIL ctr_saturate got pred=%b addr=%h exp pred=1 addr=0C0", pred_takenD, imem_addr);
        end
    endtask

    task automatic test_alias();
        redirect(13'h060);
        tick();
        checks++;
        if (pcD !== 13'h060 || pred_takenD !== 1'b0 || imem_addr !== 13'h064) begin
            errors++;
            $display("FAIL alias got pcD=%h pred=%b addr=%h exp pcD=060 pred=0 addr=064",
                     pcD, pred_takenD, imem_addr);
        end
    endtask

    task automatic test_wrap();
        redirect(13'h1FFC);
        tick();
        checks++;
        if (pcD !== 13'h1FFC || imem_addr !== 13'h0000) begin
            errors++;
            $display("FAIL pc_wrap got pcD=%h addr=%h exp pcD=1FFC addr=0000", pcD, imem_addr);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        redirect(13'h020);
        tick();
        #2;
        NRST = 1'b0;
        #1;
        checks++;
        if (imem_addr !== 13'd0 || pcD !== 13'd0 || instD !== 32'd0 || pred_takenD !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got addr=%h pcD=%h inst=%h pred=%b exp all zero",
                     imem_addr, pcD, instD, pred_takenD);
        end
        model_reset();
        @(negedge CLK);
        NRST = 1'b1;
        redirect(13'h020);
        tick();
        checks++;
        if (pcD !== 13'h020 || pred_takenD !== 1'b0 || imem_addr !== 13'h024) begin
            errors++;
            $display("FAIL reset_btb_clear got pcD=%h pred=%b addr=%h exp pcD=020 pred=0 addr=024",
                     pcD, pred_takenD, imem_addr);
        end
    endtask

    initial begin
        clr();
        test_reset();
        test_straight_line();
        test_stall();
        test_redirect_over_stall();
        test_btb_alloc();
        test_counter();
        test_alias();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
